button_conditioner: RTL and testbench

- Front-end stage directly upstream of parking_meter.
- Takes the six raw push-button inputs (add1..add4, rst1, rst2). Synchronizes and debounces them, then emits single-cycle command pulses that drive parking_meter's add/rst inputs.
- Provides hold-to-repeat on the add buttons so a held button keeps adding time, for example to reach the 9999 cap.
- Guarantees at most one command pulse per clock.

---
 rtl/button_conditioner_if.sv | 23 ++
 rtl/button_conditioner.sv | 153 +++++++++++++++
 tb/tb_button_conditioner.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Button-side bus of the conditioner: raw buttons in, command pulses and
// debounced levels out.
interface button_conditioner_if;
  logic [5:0] btn_in;
  logic       add1;
  logic       add2;
  logic       add3;
  logic       add4;
  logic       rst1;
  logic       rst2;
  logic [5:0] btn_level;

  // master drives the raw buttons, slave (the conditioner) produces commands
  modport master (
    output btn_in,
    input  add1, add2, add3, add4, rst1, rst2, btn_level
  );

  modport slave (
    input  btn_in,
    output add1, add2, add3, add4, rst1, rst2, btn_level
  );
endinterface

// File: rtl/button_conditioner.sv
// Button front end for parking_meter: two-flop synchronizer, per-bit debounce,
// press detection, hold-to-repeat on the add buttons, and fixed-priority
// arbitration so that at most one command pulse fires per clock.
// Pulse bit order everywhere: [0]=add1 [1]=add2 [2]=add3 [3]=add4 [4]=rst1 [5]=rst2.
// There is no handshake: each command is a single-cycle pulse and the
// consumer must act on it in that cycle; nothing is held or retried.
module button_conditioner #(
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 50,
  parameter int RPT_CYCLES  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus,
  output logic [1:0]           dbg_state
);

  localparam int DB_W  = $clog2(DB_CYCLES + 1);
  localparam int T_MAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
  localparam int T_W   = $clog2(T_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  logic [5:0]      sync1_q, sync1_d;
  logic [5:0]      sync2_q, sync2_d;
  logic [5:0]      stable_q, stable_d;
  logic [5:0]      prev_q, prev_d;
  logic [DB_W-1:0] cnt_q [6];
  logic [DB_W-1:0] cnt_d [6];
  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [T_W-1:0]  timer_q, timer_d;
  logic [5:0]      pulse_q, pulse_d;

  logic [5:0]      press;
  logic [5:0]      req;
  logic            rpt_req;
  logic [1:0]      pick;
  logic [5:0]      others;

  // Synchronizer and per-bit debounce: a bit flips only after DB_CYCLES
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    sync1_d  = bus.btn_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    prev_d   = stable_q;
    for (int i = 0; i < 6; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
  end

  assign press = stable_q & ~prev_q;

  // Repeat FSM: one shared timer follows a single held add button.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    rpt_req = 1'b0;
    pick    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (press[i]) pick = 2'(i);
    end
    others = stable_q & ~(6'b000001 << idx_q);
    case (state_q)
      S_IDLE: begin
        if ((|press[3:0]) && ((stable_q & ~(6'b000001 << pick)) == 6'b0)) begin
          state_d = S_HOLD;
          idx_d   = pick;
          timer_d = '0;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (!stable_q[idx_q] || (|others)) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (timer_q == ((state_q == S_HOLD) ? T_W'(HOLD_CYCLES - 1)
                                                     : T_W'(RPT_CYCLES - 1))) begin
          rpt_req = 1'b1;
          state_d = S_REPEAT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + T_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Fixed priority: the highest-numbered request wins, the rest are dropped.
  always_comb begin
    req = press;
    if (rpt_req) req[idx_q] = 1'b1;
    pulse_d = '0;
    for (int i = 0; i < 6; i++) begin
      if (req[i]) begin
        pulse_d    = '0;
        pulse_d[i] = 1'b1;
      end
    end
  end

  // All state registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
      state_q  <= S_IDLE;
      idx_q    <= '0;
      timer_q  <= '0;
      pulse_q  <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      pulse_q  <= pulse_d;
    end
  end

  assign bus.add1      = pulse_q[0];
  assign bus.add2      = pulse_q[1];
  assign bus.add3      = pulse_q[2];
  assign bus.add4      = pulse_q[3];
  assign bus.rst1      = pulse_q[4];
  assign bus.rst2      = pulse_q[5];
  assign bus.btn_level = stable_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner. Edge numbering: buttons are changed
// on a falling edge, so the next rising edge is edge 1; outputs are sampled on
// the falling edge after each rising edge.
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_err;

  button_conditioner_if bus ();

  button_conditioner #(
    .DB_CYCLES  (4),
    .HOLD_CYCLES(50),
    .RPT_CYCLES (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] pulses();
    return {bus.rst2, bus.rst1, bus.add4, bus.add3, bus.add2, bus.add1};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one rising edge, then compare the pulse outputs on the following falling edge
  task automatic tick(input string tag, input logic [5:0] exp_p);
    @(posedge clk);
    @(negedge clk);
    check(tag, {2'b00, pulses()}, {2'b00, exp_p});
  endtask

  // hold a pattern for `held` edges, then release; expects one pulse at edge 7
  task automatic press_release(input string tag, input logic [5:0] pat, input int held,
                               input int total, input logic [5:0] exp_p);
    for (int e = 1; e <= total; e++) begin
      bus.btn_in = (e <= held) ? pat : 6'b0;
      tick(tag, (e == 7) ? exp_p : 6'b0);
      if (e == 5) check({tag, "_lvl5"}, {2'b00, bus.btn_level}, 8'h00);
      if (e == 7) check({tag, "_lvl7"}, {2'b00, bus.btn_level}, {2'b00, pat});
    end
    bus.btn_in = 6'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_err      = 0;
    rst        = 1'b0;
    bus.btn_in = 6'b001001;

    // reset held with buttons pressed: nothing moves
    @(negedge clk);
    for (int e = 1; e <= 20; e++) begin
      tick("rst_hold_pulse", 6'b0);
      check("rst_hold_lvl", {2'b00, bus.btn_level}, 8'h00);
    end
    check("rst_state", {6'b0, dbg_state}, 8'h00);

    // release reset with add1+add4 held: add4 wins arbitration at edge 7
    rst = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick("rst_rel_pulse", (e == 7) ? 6'b001000 : 6'b0);
      check("rst_rel_lvl", {2'b00, bus.btn_level}, (e >= 6) ? 8'h09 : 8'h00);
    end
    check("two_held_idle", {6'b0, dbg_state}, 8'h00);
    bus.btn_in = 6'b0;
    for (int e = 1; e <= 10; e++) tick("rst_rel_drop", 6'b0);
    check("rst_rel_lvl_off", {2'b00, bus.btn_level}, 8'h00);

    // clean press on add1
    press_release("clean_add1", 6'b000001, 10, 20, 6'b000001);
    check("clean_lvl_off", {2'b00, bus.btn_level}, 8'h00);

    // clean press on rst1 (never enters the repeat FSM)
    press_release("clean_rst1", 6'b010000, 10, 20, 6'b010000);
    check("rst1_idle", {6'b0, dbg_state}, 8'h00);

    // bounce on add3: 3 high, 1 low, 3 high, then low
    for (int e = 1; e <= 20; e++) begin
      bus.btn_in = ((e <= 3) || (e >= 5 && e <= 7)) ? 6'b000100 : 6'b0;
      tick("bounce_pulse", 6'b0);
      check("bounce_lvl", {2'b00, bus.btn_level}, 8'h00);
    end

    // simultaneous rst2 + add1: rst2 wins
    press_release("simul", 6'b100001, 10, 20, 6'b100000);
    check("simul_idle", {6'b0, dbg_state}, 8'h00);

    // hold-repeat on add4: pulses at 7, 57, 67, 77
    for (int e = 1; e <= 90; e++) begin
      bus.btn_in = (e <= 75) ? 6'b001000 : 6'b0;
      tick("hold_pulse", (e == 7 || e == 57 || e == 67 || e == 77) ? 6'b001000 : 6'b0);
      if (e == 8)  check("hold_state", {6'b0, dbg_state}, 8'h01);
      if (e == 58) check("repeat_state", {6'b0, dbg_state}, 8'h02);
      if (e == 80) check("hold_lvl80", {2'b00, bus.btn_level}, 8'h08);
      if (e == 81) check("hold_lvl81", {2'b00, bus.btn_level}, 8'h00);
    end
    check("hold_end_idle", {6'b0, dbg_state}, 8'h00);

    // reset in the middle of the repeat sequence
    for (int e = 1; e <= 57; e++) begin
      bus.btn_in = 6'b001000;
      tick("mid_pre_pulse", (e == 7 || e == 57) ? 6'b001000 : 6'b0);
    end
    #1 rst = 1'b0;
    #1;
    check("mid_async_pulse", {2'b00, pulses()}, 8'h00);
    check("mid_async_lvl", {2'b00, bus.btn_level}, 8'h00);
    check("mid_async_state", {6'b0, dbg_state}, 8'h00);
    for (int e = 1; e <= 5; e++) tick("mid_rst_low", 6'b0);
    rst = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      tick("mid_post_pulse", (e == 7 || e == 57) ? 6'b001000 : 6'b0);
      if (e == 6) check("mid_post_lvl", {2'b00, bus.btn_level}, 8'h08);
    end
    bus.btn_in = 6'b0;
    for (int e = 1; e <= 20; e++) tick("mid_release", 6'b0);
    check("mid_end_lvl", {2'b00, bus.btn_level}, 8'h00);
    check("mid_end_state", {6'b0, dbg_state}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
